hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Sits beside the EX-stage forwarding unit and covers the hazards forwarding cannot resolve:
  - load-use stalls;
  - branch-in-ID operand stalls;
  - taken-branch IF/ID flush;
  - stalls behind the multi-cycle mult/div unit, tracked by an internal busy FSM.
- Drives PC/IF-ID write enables and IF/ID and ID/EX flushes.

Parameters:
- MULT_CYCLES, 4, EX-occupancy cycles of mult/multu (>=1)
- DIV_CYCLES, 32, EX-occupancy cycles of div/divu (>=1)
- CNT_W, 6, busy-counter width; must hold max(MULT_CYCLES,DIV_CYCLES)-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- id_rs, id_rt  in  5 each  source regs of instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads that source
- id_is_branch  in  1  beq/bne in ID; compare is done in ID
- id_branch_taken  in  1  ID compare result, taken
- id_uses_hilo  in  1  mfhi/mflo/mthi/mtlo in ID
- id_is_md  in  1  mult/div class instruction in ID
- ex_dst  in  5  destination reg of EX instruction
- ex_RegWrite, ex_MemRead  in  1 each  EX control
- mem_dst  in  5  destination reg of MEM instruction
- mem_MemRead  in  1  MEM is a load
- ex_md_start  in  1  mult/div entering EX this cycle
- ex_md_is_div  in  1  qualifies ex_md_start: 1=div, 0=mult
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  zero IF/ID on next edge
- idex_flush  out  1  insert bubble into ID/EX on next edge
- md_busy  out  1  mult/div unit occupied
- md_done  out  1  one-cycle pulse, HI/LO valid
- stall_cycles  out  32  count of stalled cycles, saturating

Behaviour:
- Register r0 never creates a hazard. Any match against dst==0 is ignored.
- Combinational stall terms:
  - match_ex = (id_uses_rs && id_rs==ex_dst) || (id_uses_rt && id_rt==ex_dst), with ex_dst!=0. match_mem is the same form against mem_dst.
  - load_use = ex_MemRead && match_ex
  - br_haz = id_is_branch && ((ex_RegWrite && match_ex) || (mem_MemRead && match_mem))
  - md_haz = md_busy && (id_uses_hilo || id_is_md)
  - stall = load_use || br_haz || md_haz
- Outputs are combinational from inputs and FSM state (zero latency):
  - pc_write = ifid_write = !stall
  - idex_flush = stall
  - ifid_flush = id_branch_taken && !stall. Stall has priority because the branch compare used stale operands.
- Mult/div FSM, registered; states IDLE, BUSY, DONE:
  - IDLE: on ex_md_start, go to BUSY. cnt loads DIV_CYCLES-1 if ex_md_is_div, else MULT_CYCLES-1.
  - BUSY: md_busy=1. If cnt==0, go to DONE; else cnt decrements. ex_md_start in BUSY is a protocol violation and is ignored.
  - DONE: md_done=1 and md_busy=0 for exactly one cycle. Then IDLE, or BUSY if ex_md_start is high (back-to-back accepted, cnt reloaded).
  - A start with a loaded value of 0 spends 1 cycle in BUSY. Total busy = configured cycles.
- stall_cycles increments at each edge where stall=1 and saturates at 32'hFFFFFFFF. It is not cleared except by rst.
- Reset (asynchronous, effective immediately, including mid-BUSY):
  - state=IDLE, cnt=0, stall_cycles=0, md_busy=0, md_done=0.
  - While rst=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1. This holds the pipeline empty.
  - First edge after rst falls: normal operation.
- Simultaneous events:
  - load_use and md_haz together still give a single stall cycle per edge; the counter increments by 1.
  - A taken branch during a stall is re-evaluated next cycle.

Test Plan:
1. Load-use:
   - Stimulus: ex_MemRead=1, ex_dst=5; ID id_uses_rt=1, id_rt=5.
   - Required: pc_write=0, ifid_write=0, idex_flush=1 for 1 cycle; stall_cycles 0->1. Repeat with ex_dst=0: no stall.
2. Branch operand:
   - Stimulus: id_is_branch=1, id_rs=8, ex_RegWrite=1, ex_dst=8, id_branch_taken=1.
   - Required: stall=1, ifid_flush=0.
   - Next cycle, with ex_dst=0 and mem_MemRead=0: stall=0, ifid_flush=1.
3. Mult busy:
   - Stimulus: ex_md_start=1, ex_md_is_div=0, MULT_CYCLES=4; id_uses_hilo=1 held.
   - Required: md_busy high 4 cycles; stall 4 cycles; md_done pulses in cycle 5 with stall=0; stall_cycles=4.
4. Div back-to-back:
   - Stimulus: div start with DIV_CYCLES=32; ex_md_start=1 again in the DONE cycle.
   - Required: md_busy=1 for 32 cycles, md_done 1 cycle, md_busy=1 for another 32 cycles.
5. Reset mid-div:
   - Stimulus: assert rst at busy cycle 10, off-edge.
   - Required: md_busy=0 immediately, pc_write=0, ifid_flush=1, idex_flush=1; after release, state IDLE and stall_cycles=0.
6. Saturation:
   - Stimulus: force stall_cycles near max; hold load_use.
   - Required: counter reaches 32'hFFFFFFFF and stays there.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline. It covers the hazards that forwarding
// cannot resolve: load-use, branch-in-ID operands, taken-branch flush and mult/div occupancy.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_branch,
  input  logic        id_branch_taken,
  input  logic        id_uses_hilo,
  input  logic        id_is_md,
  input  logic [4:0]  ex_dst,
  input  logic        ex_RegWrite,
  input  logic        ex_MemRead,
  input  logic [4:0]  mem_dst,
  input  logic        mem_MemRead,
  input  logic        ex_md_start,
  input  logic        ex_md_is_div,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_e;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic match_ex, match_mem, load_use, br_haz, md_haz, stall;

  // Hazard detection; r0 is hardwired to zero, so it never carries a dependency.
  always_comb begin
    match_ex  = (ex_dst != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_dst)) || (id_uses_rt && (id_rt == ex_dst)));
    match_mem = (mem_dst != 5'd0) &&
                ((id_uses_rs && (id_rs == mem_dst)) || (id_uses_rt && (id_rt == mem_dst)));
    load_use  = ex_MemRead && match_ex;
    br_haz    = id_is_branch && ((ex_RegWrite && match_ex) || (mem_MemRead && match_mem));
    md_haz    = md_busy && (id_uses_hilo || id_is_md);
    stall     = load_use || br_haz || md_haz;
  end

  assign md_busy      = (state_q == S_BUSY);
  assign md_done      = (state_q == S_DONE);
  assign stall_cycles = stall_cnt_q;

  // A stalled branch compared stale operands, so the flush waits for the re-evaluation.
  // Reset holds the front end frozen and flushed so the pipeline stays empty.
  always_comb begin
    pc_write   = !stall;
    ifid_write = !stall;
    idex_flush = stall;
    ifid_flush = id_branch_taken && !stall;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
  // which is what keeps synthesis from inferring a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (ex_md_start) begin
          state_d = S_BUSY;
          cnt_d   = ex_md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE: begin
        if (ex_md_start) begin
          state_d = S_BUSY;
          cnt_d   = ex_md_is_div ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
